// File: rtl/ps2_mouse_interface.sv
// PS/2 mouse host: enables streaming with 0xF4/0xFA, then deframes device bytes into 3-byte packets.
// Outputs update one cycle after the fall that samples byte 2's stop bit; new_data strobes for that cycle.
module ps2_mouse_interface #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int HOLD_US    = 100,
  parameter int TIMEOUT_US = 2000,
  parameter int FILTER_LEN = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       new_data,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       m1,
  output logic       m2,
  output logic       m3,
  output logic       stream_ready
);

  localparam int unsigned HOLD_CYC = int'((64'(HOLD_US) * 64'(CLK_HZ)) / 64'd1_000_000);
  localparam int unsigned TMO_CYC  = int'((64'(TIMEOUT_US) * 64'(CLK_HZ)) / 64'd1_000_000);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [7:0] CMD     = 8'hF4;
  localparam logic [7:0] ACK     = 8'hFA;
  localparam logic [9:0] TX_BITS = {1'b1, ~^CMD, CMD};

  typedef enum logic [2:0] {INIT_HOLD, INIT_REQ, TX, TX_ACK, WAIT_FA, STREAM} state_t;

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q, fall_q;
  logic [FW-1:0] fcnt_q;
  logic          clk_s, dat_s;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      dat_sync_q <= {dat_sync_q[0], ps2_data_in};
      fall_q     <= 1'b0;
      if (clk_s == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q <= clk_s;
        fcnt_q <= '0;
        fall_q <= filt_q;
      end else begin
        fcnt_q <= fcnt_q + FW'(1);
      end
    end
  end

  state_t        state_q;
  logic [HW-1:0] hold_q;
  logic [TW-1:0] tmo_q;
  logic [3:0]    txi_q, rxcnt_q;
  logic [9:0]    sr_q;
  logic [1:0]    pidx_q;
  logic [7:0]    b0_q, b1_q;
  logic          clk_oe_q, data_oe_q, new_q, rdy_q;
  logic [8:0]    dx_q, dy_q;
  logic [2:0]    btn_q;

  logic       tmo_exp, frame_done, frame_ok, restart;
  logic [7:0] rx_byte;

  assign tmo_exp    = (tmo_q == TW'(TMO_CYC - 1));
  assign frame_done = fall_q && (rxcnt_q == 4'd10);
  assign frame_ok   = ~sr_q[0] & (^sr_q[9:1]) & dat_s;
  assign rx_byte    = sr_q[8:1];

  // Any abort of the init handshake funnels back to INIT_HOLD for a full retry.
  always_comb begin
    restart = 1'b0;
    case (state_q)
      TX:      restart = tmo_exp;
      TX_ACK:  restart = tmo_exp | (fall_q & dat_s);
      WAIT_FA: restart = tmo_exp | (frame_done & ~(frame_ok & (rx_byte == ACK)));
      default: restart = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= INIT_HOLD;
      hold_q    <= '0;
      tmo_q     <= '0;
      txi_q     <= '0;
      rxcnt_q   <= '0;
      sr_q      <= '0;
      pidx_q    <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      new_q     <= 1'b0;
      rdy_q     <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
      btn_q     <= '0;
    end else begin
      new_q <= 1'b0;
      if (fall_q || tmo_exp || state_q == INIT_HOLD || state_q == INIT_REQ) tmo_q <= '0;
      else tmo_q <= tmo_q + TW'(1);

      if (restart) begin
        state_q   <= INIT_HOLD;
        hold_q    <= HW'(1);
        clk_oe_q  <= 1'b1;
        data_oe_q <= 1'b0;
      end else begin
        case (state_q)
          INIT_HOLD: begin
            if (hold_q == HW'(HOLD_CYC)) begin
              clk_oe_q  <= 1'b0;
              data_oe_q <= 1'b1;
              state_q   <= INIT_REQ;
            end else begin
              clk_oe_q  <= 1'b1;
              data_oe_q <= 1'b0;
              hold_q    <= hold_q + HW'(1);
            end
          end
          INIT_REQ: begin
            txi_q   <= '0;
            rxcnt_q <= '0;
            state_q <= TX;
          end
          TX: if (fall_q) begin
            data_oe_q <= ~TX_BITS[txi_q];
            txi_q     <= txi_q + 4'd1;
            if (txi_q == 4'd9) state_q <= TX_ACK;
          end
          TX_ACK: if (fall_q) state_q <= WAIT_FA;
          default: begin
            // Receive path shared by WAIT_FA and STREAM; timeout wins over a coincident fall.
            if (tmo_exp) begin
              if (rxcnt_q != 4'd0) begin
                rxcnt_q <= '0;
                pidx_q  <= '0;
              end
            end else if (frame_done) begin
              rxcnt_q <= '0;
              if (state_q == WAIT_FA) begin
                state_q <= STREAM;
                rdy_q   <= 1'b1;
                pidx_q  <= '0;
              end else if (!frame_ok) begin
                pidx_q <= '0;
              end else begin
                case (pidx_q)
                  2'd0: if (rx_byte[3]) begin
                    b0_q   <= rx_byte;
                    pidx_q <= 2'd1;
                  end
                  2'd1: begin
                    b1_q   <= rx_byte;
                    pidx_q <= 2'd2;
                  end
                  default: begin
                    dx_q   <= b0_q[6] ? 9'd0 : {b0_q[4], b1_q};
                    dy_q   <= b0_q[7] ? 9'd0 : {b0_q[5], rx_byte};
                    btn_q  <= b0_q[2:0];
                    new_q  <= 1'b1;
                    pidx_q <= 2'd0;
                  end
                endcase
              end
            end else if (fall_q) begin
              sr_q    <= {dat_s, sr_q[9:1]};
              rxcnt_q <= rxcnt_q + 4'd1;
            end
          end
        endcase
      end
    end
  end

  assign ps2_clk_oe   = clk_oe_q;
  assign ps2_data_oe  = data_oe_q;
  assign new_data     = new_q;
  assign dx           = dx_q;
  assign dy           = dy_q;
  assign m1           = btn_q[0];
  assign m2           = btn_q[1];
  assign m3           = btn_q[2];
  assign stream_ready = rdy_q;

endmodule

// File: tb/tb_ps2_mouse_interface.sv
// Bench: behavioural PS/2 device on a wired-AND bus, packet reference model and scoreboard.
module tb_ps2_mouse_interface;
  localparam int CLK_HZ = 2_000_000;
  localparam int HOLD_US = 100;
  localparam int TIMEOUT_US = 2000;
  localparam int FILTER_LEN = 8;
  localparam int HOLD_CYC = HOLD_US * (CLK_HZ / 1_000_000);
  localparam int TMO_CYC = TIMEOUT_US * (CLK_HZ / 1_000_000);
  localparam int H = 20;
  localparam int Q = 10;

  logic Clk = 1'b0, Reset = 1'b1;
  logic dev_clk = 1'b1, dev_data = 1'b1;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, new_data, m1, m2, m3, stream_ready;
  logic [8:0] dx, dy;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_mouse_interface #(.CLK_HZ(CLK_HZ), .HOLD_US(HOLD_US), .TIMEOUT_US(TIMEOUT_US),
                        .FILTER_LEN(FILTER_LEN)) dut (
    .Clk(Clk), .Reset(Reset), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .new_data(new_data),
    .dx(dx), .dy(dy), .m1(m1), .m2(m2), .m3(m3), .stream_ready(stream_ready));

  always #5 Clk = ~Clk;

  int n_cmp = 0, n_err = 0;
  logic [7:0]  pend[$];
  logic [20:0] exp_q[$], obs_q[$];
  logic [20:0] last_exp = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Spec-level model: collect accepted bytes; a bad byte or aborted frame empties the packet.
  function automatic void model_byte(input logic [7:0] b, input bit ok);
    logic [8:0] ex, ey;
    if (!ok) pend.delete();
    else if (pend.size() == 0 && !b[3]) return;
    else begin
      pend.push_back(b);
      if (pend.size() == 3) begin
        ex = pend[0][6] ? 9'd0 : {pend[0][4], pend[1]};
        ey = pend[0][7] ? 9'd0 : {pend[0][5], pend[2]};
        exp_q.push_back({ex, ey, pend[0][2], pend[0][1], pend[0][0]});
        pend.delete();
      end
    end
  endfunction

  always @(negedge Clk) begin
    if (!Reset && new_data) begin
      obs_q.push_back({dx, dy, m3, m2, m1});
      check("strobe_in_stream", stream_ready, 1);
    end
  end

  // err: 0 good, 1 bad parity, 2 bad start, 3 bad stop; nbits < 11 aborts mid-frame.
  task automatic dev_tx(input logic [7:0] b, input int err, input int nbits);
    logic [10:0] f;
    f = {err != 3, (~^b) ^ (err == 1), b, err == 2};
    for (int i = 0; i < nbits; i++) begin
      dev_data = f[i];
      cyc(Q);
      dev_clk = 1'b0;
      cyc(H);
      dev_clk = 1'b1;
      cyc(Q);
    end
    dev_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int err);
    dev_tx(b, err, 11);
    model_byte(b, err == 0);
    cyc(20);
  endtask

  task automatic host_frame(output logic [7:0] b, output logic p, output logic s, input logic ack);
    logic [9:0] bits;
    int t = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < 4 * HOLD_CYC) begin
      cyc(1);
      t++;
    end
    check("host_request_seen", (t < 4 * HOLD_CYC), 1);
    cyc(40);
    for (int k = 0; k < 10; k++) begin
      dev_clk = 1'b0;
      cyc(H);
      dev_clk = 1'b1;
      bits[k] = ps2_data_in;
      cyc(H);
    end
    dev_data = ack;
    cyc(Q);
    dev_clk = 1'b0;
    cyc(H);
    dev_clk = 1'b1;
    cyc(Q);
    dev_data = 1'b1;
    b = bits[7:0];
    p = bits[8];
    s = bits[9];
  endtask

  task automatic do_init(input logic [7:0] reply);
    logic [7:0] b;
    logic p, s;
    host_frame(b, p, s, 1'b0);
    check("tx_byte", b, 8'hF4);
    check("tx_parity", p, 0);
    check("tx_stop", s, 1);
    cyc(30);
    dev_tx(reply, 0, 11);
    cyc(30);
  endtask

  task automatic wait_ready;
    int t = 0;
    while (!stream_ready && t < 1000) begin
      cyc(1);
      t++;
    end
    check("stream_ready", stream_ready, 1);
  endtask

  task automatic expect_packets(input string tag);
    int n;
    cyc(30);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_pkt"}, obs_q[i], exp_q[i]);
    if (exp_q.size() > 0) last_exp = exp_q[exp_q.size() - 1];
    check({tag, "_hold"}, {dx, dy, m3, m2, m1}, last_exp);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    logic [7:0] b;
    cyc(5);
    check("rst_new_data", new_data, 0);
    check("rst_dxdy", {dx, dy}, 0);
    check("rst_buttons", {m3, m2, m1}, 0);
    check("rst_ready", stream_ready, 0);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);

    @(negedge Clk);
    Reset = 1'b0;
    n = 0;
    for (int i = 0; i < HOLD_CYC + 100; i++) begin
      @(negedge Clk);
      if (ps2_clk_oe) n++;
      else if (n > 0) break;
    end
    check("hold_cycles", n, HOLD_CYC);
    do_init(8'hFA);
    wait_ready();

    send_byte(8'h29, 0); send_byte(8'h05, 0); send_byte(8'hFB, 0);
    expect_packets("basic");
    send_byte(8'h05, 0); send_byte(8'h0A, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    expect_packets("realign");
    send_byte(8'h08, 0); send_byte(8'h10, 1);
    send_byte(8'h08, 0); send_byte(8'h10, 0); send_byte(8'h20, 0);
    expect_packets("parity_err");
    send_byte(8'h08, 0); send_byte(8'h10, 0); send_byte(8'h20, 2); send_byte(8'h20, 3);
    send_byte(8'h1C, 0); send_byte(8'h7F, 0); send_byte(8'h80, 0);
    expect_packets("frame_err");

    send_byte(8'h08, 0);
    dev_tx(8'h33, 0, 5);
    pend.delete();
    cyc(TMO_CYC + 1000);
    send_byte(8'h18, 0); send_byte(8'hFF, 0); send_byte(8'h01, 0);
    expect_packets("timeout");
    send_byte(8'h48, 0); send_byte(8'h80, 0); send_byte(8'h03, 0);
    expect_packets("overflow");

    for (int k = 0; k < 14; k++) begin
      for (int j = 0; j < 3; j++) begin
        b = 8'($urandom);
        if (j == 0 && $urandom_range(0, 3) != 0) b[3] = 1'b1;
        send_byte(b, ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
    end
    expect_packets("random");

    Reset = 1'b1;
    cyc(3);
    Reset = 1'b0;
    n = 0;
    while (ps2_data_oe !== 1'b1 && n < 4 * HOLD_CYC) begin
      cyc(1);
      n++;
    end
    cyc(40);
    for (int k = 0; k < 3; k++) begin
      dev_clk = 1'b0; cyc(H); dev_clk = 1'b1; cyc(H);
    end
    Reset = 1'b1;
    #1;
    check("midtx_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("midtx_rst_ready", stream_ready, 0);
    cyc(3);
    Reset = 1'b0;
    do_init(8'hFE);
    n = 0;
    while (!ps2_clk_oe && n < 500) begin
      cyc(1);
      n++;
    end
    check("nack_retry_hold", ps2_clk_oe, 1);
    check("nack_not_ready", stream_ready, 0);
    do_init(8'hFA);
    wait_ready();
    last_exp = '0;
    send_byte(8'h09, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
    expect_packets("after_retry");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
